// File: rtl/neuro_nav_pkg.sv
// Shared definitions for the LIF spike encoder and the navigation/SLAM
// peripheral it feeds.
//   - lif_state_t : per-channel neuron state (IDLE, FIRE, REFRACT)
//   - V_W, CNT_W  : membrane potential and statistics counter widths
//   - LEAK_W      : width of the global leak counter / leak period
//   - TMR_W       : width of the pulse / refractory timers
//   - CH_*        : spike_out bit index per heading, shared with the SLAM block
//   - sat_add_v   : membrane add that clamps at all-ones instead of wrapping
package neuro_nav_pkg;

  localparam int V_W    = 8;
  localparam int CNT_W  = 16;
  localparam int LEAK_W = 8;
  localparam int TMR_W  = 4;

  localparam int CH_EAST  = 0;
  localparam int CH_NORTH = 1;
  localparam int CH_WEST  = 2;
  localparam int CH_SOUTH = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    REFRACT = 2'd2
  } lif_state_t;

  // Membrane add; one extra bit catches the carry so the result clamps at
  // 2^V_W-1 before any leak is subtracted.
  function automatic logic [V_W-1:0] sat_add_v(input logic [V_W-1:0] v,
                                               input logic [TMR_W-1:0] w);
    logic [V_W:0] sum;
    sum = {1'b0, v} + (V_W+1)'(w);
    return sum[V_W] ? {V_W{1'b1}} : sum[V_W-1:0];
  endfunction

endpackage

// File: rtl/lif_channel.sv
// One leaky integrate-and-fire neuron: membrane, state machine and timer.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en                : 0 forces IDLE with v=0, tmr=0 (truncates a spike)
//   evt               : raw event line for this channel
//   leak_tick         : one-cycle leak strobe from the shared leak counter
//   cfg_weight        : membrane increment per event
//   cfg_threshold     : fire threshold (0 behaves as 1)
//   cfg_pulse_len     : spike high time minus one
//   cfg_refractory    : post-spike low time minus one
//   spike             : registered spike line
//   busy              : channel is in FIRE or REFRACT
//   fire_pulse        : this cycle's edge moves the channel into FIRE
//   drop_pulse        : an event is being ignored because the channel is busy
module lif_channel
  import neuro_nav_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             evt,
  input  logic             leak_tick,
  input  logic [TMR_W-1:0] cfg_weight,
  input  logic [V_W-1:0]   cfg_threshold,
  input  logic [TMR_W-1:0] cfg_pulse_len,
  input  logic [TMR_W-1:0] cfg_refractory,
  output logic             spike,
  output logic             busy,
  output logic             fire_pulse,
  output logic             drop_pulse
);

  lif_state_t       state_reg, state_next;
  logic [V_W-1:0]   v_reg, v_next;
  logic [TMR_W-1:0] tmr_reg, tmr_next;
  logic             spike_reg;

  logic [V_W-1:0]   v_add;
  logic [V_W-1:0]   v_leak;
  logic [V_W-1:0]   thr_eff;

  always_comb begin
    // Saturated add first, then the leak, floored at zero.
    v_add   = sat_add_v(v_reg, evt ? cfg_weight : '0);
    v_leak  = (leak_tick && (v_add != '0)) ? v_add - V_W'(1) : v_add;
    thr_eff = (cfg_threshold == '0) ? V_W'(1) : cfg_threshold;

    state_next = state_reg;
    v_next     = v_reg;
    tmr_next   = tmr_reg;
    fire_pulse = 1'b0;

    case (state_reg)
      IDLE: begin
        if (v_leak >= thr_eff) begin
          state_next = FIRE;
          v_next     = '0;
          tmr_next   = cfg_pulse_len;   // latched here; later cfg edits wait
          fire_pulse = 1'b1;
        end else begin
          v_next = v_leak;
        end
      end
      FIRE: begin
        v_next = '0;
        if (tmr_reg == '0) begin
          state_next = REFRACT;
          tmr_next   = cfg_refractory;
        end else begin
          tmr_next = tmr_reg - TMR_W'(1);
        end
      end
      REFRACT: begin
        v_next = '0;
        if (tmr_reg == '0) begin
          state_next = IDLE;
        end else begin
          tmr_next = tmr_reg - TMR_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        v_next     = '0;
        tmr_next   = '0;
      end
    endcase

    if (!en) begin
      state_next = IDLE;
      v_next     = '0;
      tmr_next   = '0;
      fire_pulse = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      v_reg     <= '0;
      tmr_reg   <= '0;
      spike_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      v_reg     <= v_next;
      tmr_reg   <= tmr_next;
      // Spike comes straight from a flop so the SLAM edge detector never
      // sees a decode glitch.
      spike_reg <= (state_next == FIRE);
    end
  end

  assign spike      = spike_reg;
  assign busy       = (state_reg != IDLE);
  assign drop_pulse = evt && busy;

endmodule

// File: rtl/lif_spike_encoder.sv
// Multi-channel LIF front-end turning raw event lines into rate-coded
// direction spikes for the navigation/SLAM peripheral (bit CH_EAST..CH_SOUTH).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en                : 0 idles all channels, clears the leak counter,
//                       holds the statistics counters
//   in_evt            : raw event lines, one per channel
//   cfg_weight        : membrane increment per event
//   cfg_threshold     : fire threshold (0 behaves as 1)
//   cfg_leak_period   : leak every N enabled cycles, 0 = no leak
//   cfg_pulse_len     : spike high time minus one
//   cfg_refractory    : post-spike low time minus one
//   spike_out         : registered spike lines
//   busy              : per-channel FIRE/REFRACT indicator
//   fire_count        : total spikes emitted, wrapping
//   drop_count        : events ignored while busy, saturating
module lif_spike_encoder
  import neuro_nav_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_CH-1:0]   in_evt,
  input  logic [TMR_W-1:0]  cfg_weight,
  input  logic [V_W-1:0]    cfg_threshold,
  input  logic [LEAK_W-1:0] cfg_leak_period,
  input  logic [TMR_W-1:0]  cfg_pulse_len,
  input  logic [TMR_W-1:0]  cfg_refractory,
  output logic [N_CH-1:0]   spike_out,
  output logic [N_CH-1:0]   busy,
  output logic [CNT_W-1:0]  fire_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int PC_W = $clog2(N_CH + 1);

  logic [LEAK_W-1:0] leak_cnt_reg;
  logic [LEAK_W-1:0] leak_cnt_inc;
  logic              leak_tick;

  logic [N_CH-1:0]   fire_pulse;
  logic [N_CH-1:0]   drop_pulse;
  logic [PC_W-1:0]   fire_sum;
  logic [PC_W-1:0]   drop_sum;
  logic [CNT_W:0]    drop_wide;

  logic [CNT_W-1:0]  fire_count_reg;
  logic [CNT_W-1:0]  drop_count_reg;

  // Leak counter: the incremented value is what gets matched, so a period
  // of N yields a tick every N enabled cycles. A period written below the
  // current count is only met after the 8-bit counter wraps.
  assign leak_cnt_inc = leak_cnt_reg + LEAK_W'(1);
  assign leak_tick    = en && (cfg_leak_period != '0) &&
                        (leak_cnt_inc == cfg_leak_period);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      leak_cnt_reg <= '0;
    end else if (leak_tick) begin
      leak_cnt_reg <= '0;
    end else begin
      leak_cnt_reg <= leak_cnt_inc;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    lif_channel u_ch (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .evt            (in_evt[gi]),
      .leak_tick      (leak_tick),
      .cfg_weight     (cfg_weight),
      .cfg_threshold  (cfg_threshold),
      .cfg_pulse_len  (cfg_pulse_len),
      .cfg_refractory (cfg_refractory),
      .spike          (spike_out[gi]),
      .busy           (busy[gi]),
      .fire_pulse     (fire_pulse[gi]),
      .drop_pulse     (drop_pulse[gi])
    );
  end

  always_comb begin
    fire_sum = '0;
    drop_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      fire_sum = fire_sum + PC_W'(fire_pulse[i]);
      drop_sum = drop_sum + PC_W'(drop_pulse[i]);
    end
  end

  assign drop_wide = {1'b0, drop_count_reg} + (CNT_W+1)'(drop_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      fire_count_reg <= '0;
      drop_count_reg <= '0;
    end else if (en) begin
      fire_count_reg <= fire_count_reg + CNT_W'(fire_sum);
      drop_count_reg <= drop_wide[CNT_W] ? {CNT_W{1'b1}} : drop_wide[CNT_W-1:0];
    end
  end

  assign fire_count = fire_count_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_lif_spike_encoder.sv
// Self-checking bench for lif_spike_encoder: a cycle-counting behavioural
// model (remaining high / low cycles per channel) is compared against the
// DUT after every clock edge, and directed scenarios pin a few literals.
module tb_lif_spike_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  in_evt;
  logic [3:0]  cfg_weight;
  logic [7:0]  cfg_threshold;
  logic [7:0]  cfg_leak_period;
  logic [3:0]  cfg_pulse_len;
  logic [3:0]  cfg_refractory;
  logic [3:0]  spike_out;
  logic [3:0]  busy;
  logic [15:0] fire_count;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lif_spike_encoder #(.N_CH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .in_evt          (in_evt),
    .cfg_weight      (cfg_weight),
    .cfg_threshold   (cfg_threshold),
    .cfg_leak_period (cfg_leak_period),
    .cfg_pulse_len   (cfg_pulse_len),
    .cfg_refractory  (cfg_refractory),
    .spike_out       (spike_out),
    .busy            (busy),
    .fire_count      (fire_count),
    .drop_count      (drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_hi: spike-high cycles still to come; m_lo: refractory cycles still to come.
  int m_v[4];
  int m_hi[4];
  int m_lo[4];
  int m_lcnt;
  int m_fire;
  int m_drop;

  task automatic model_step();
    int thr, a, fires, drops;
    bit tick;
    if (rst) begin
      for (int c = 0; c < 4; c++) begin m_v[c] = 0; m_hi[c] = 0; m_lo[c] = 0; end
      m_lcnt = 0; m_fire = 0; m_drop = 0;
    end else if (!en) begin
      for (int c = 0; c < 4; c++) begin m_v[c] = 0; m_hi[c] = 0; m_lo[c] = 0; end
      m_lcnt = 0;
    end else begin
      tick = 0;
      m_lcnt = (m_lcnt + 1) % 256;
      if (cfg_leak_period != 0 && m_lcnt == int'(cfg_leak_period)) begin
        tick = 1;
        m_lcnt = 0;
      end
      thr = (cfg_threshold == 0) ? 1 : int'(cfg_threshold);
      fires = 0; drops = 0;
      for (int c = 0; c < 4; c++) begin
        if (m_hi[c] > 0) begin
          if (in_evt[c]) drops++;
          m_hi[c]--;
          if (m_hi[c] == 0) m_lo[c] = int'(cfg_refractory) + 1;
        end else if (m_lo[c] > 0) begin
          if (in_evt[c]) drops++;
          m_lo[c]--;
        end else begin
          a = m_v[c] + (in_evt[c] ? int'(cfg_weight) : 0);
          if (a > 255) a = 255;
          if (tick && a > 0) a--;
          if (a >= thr) begin
            m_v[c] = 0;
            m_hi[c] = int'(cfg_pulse_len) + 1;
            fires++;
          end else begin
            m_v[c] = a;
          end
        end
      end
      m_fire = (m_fire + fires) % 65536;
      m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] e_spk, e_busy;
    for (int c = 0; c < 4; c++) begin
      e_spk[c]  = (m_hi[c] > 0);
      e_busy[c] = (m_hi[c] > 0) || (m_lo[c] > 0);
    end
    check("model_spike_out", 32'(spike_out), 32'(e_spk));
    check("model_busy", 32'(busy), 32'(e_busy));
    check("model_fire_count", 32'(fire_count), 32'(m_fire));
    check("model_drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    compare_outputs();
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int w, input int thr, input int lp, input int pl, input int rf);
    cfg_weight      = 4'(w);
    cfg_threshold   = 8'(thr);
    cfg_leak_period = 8'(lp);
    cfg_pulse_len   = 4'(pl);
    cfg_refractory  = 4'(rf);
  endtask

  task automatic clear_chans();
    in_evt = 4'b0000;
    en = 1'b0;
    step(1);
    en = 1'b1;
  endtask

  // Feed events on one channel until it spikes; returns the event count.
  task automatic events_to_fire(input int ch, input int limit, output int n);
    n = 0;
    in_evt = 4'b0000;
    in_evt[ch] = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      step(1);
      if (spike_out[ch]) begin n = k; break; end
    end
    in_evt = 4'b0000;
  endtask

  initial begin
    int exp_spk[6]  = '{1, 1, 0, 0, 0, 0};
    int exp_busy[6] = '{1, 1, 1, 1, 1, 0};
    logic [15:0] fc0, dc0;
    int seen, n, n_rise, prev;
    int rise_t[8];
    int rise_d[8];
    bit reached;

    rst = 1'b1; en = 1'b0; in_evt = 4'b0000;
    set_cfg(0, 0, 0, 0, 0);
    step(3);
    check("reset_spike_out", 32'(spike_out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_fire_count", 32'(fire_count), 32'h0);
    check("reset_drop_count", 32'(drop_count), 32'h0);
    rst = 1'b0; en = 1'b1;
    step(2);

    // Basic fire: 3 x 4 = 12 reaches threshold on the third sample;
    // high 2 cycles, refractory 3 cycles, then idle.
    set_cfg(4, 12, 0, 1, 2);
    fc0 = fire_count;
    in_evt = 4'b0001;
    step(3);
    in_evt = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("basic_spike_c%0d", i), 32'(spike_out[0]), 32'(exp_spk[i]));
      check($sformatf("basic_busy_c%0d", i), 32'(busy[0]), 32'(exp_busy[i]));
      step(1);
    end
    check("basic_fire_count", 32'(16'(fire_count - fc0)), 32'd1);

    // Leak: sparse events decay away; dense events must cross 10 within 8.
    clear_chans();
    set_cfg(2, 10, 3, 0, 0);
    seen = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 8; c++) begin
        in_evt = (c == 0) ? 4'b0001 : 4'b0000;
        step(1);
        seen = seen | int'(spike_out[0]);
      end
    end
    check("leak_sparse_no_spike", 32'(seen), 32'd0);
    events_to_fire(0, 12, n);
    check("leak_dense_fires", 32'(n >= 6 && n <= 8), 32'd1);
    step(4);

    // Refractory drop: held event, pulse 1 cycle, refractory 4 cycles and
    // one idle sampling cycle -> a spike every 6 cycles with 5 drops each.
    clear_chans();
    set_cfg(15, 1, 0, 0, 3);
    in_evt = 4'b0100;
    n_rise = 0; prev = 0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (spike_out[2] && prev == 0 && n_rise < 8) begin
        rise_t[n_rise] = c;
        rise_d[n_rise] = int'(drop_count);
        n_rise++;
      end
      prev = int'(spike_out[2]);
    end
    in_evt = 4'b0000;
    check("refr_rises", 32'(n_rise >= 3), 32'd1);
    if (n_rise >= 3) begin
      check("refr_period", 32'(rise_t[2] - rise_t[1]), 32'd6);
      check("refr_drops_per_period", 32'(rise_d[2] - rise_d[1]), 32'd5);
    end
    step(6);

    // Saturation: 17 x 15 = 255; with weight 10 the 26th add clamps to 255.
    clear_chans();
    set_cfg(15, 255, 0, 0, 0);
    events_to_fire(1, 40, n);
    check("sat_w15_events", 32'(n), 32'd17);
    step(3);
    clear_chans();
    set_cfg(10, 255, 0, 0, 0);
    events_to_fire(1, 40, n);
    check("sat_w10_clamp_events", 32'(n), 32'd26);
    step(3);

    // Simultaneous crossing on all channels.
    clear_chans();
    set_cfg(4, 8, 0, 2, 1);
    fc0 = fire_count;
    in_evt = 4'b1111;
    step(2);
    in_evt = 4'b0000;
    check("simul_spike_all", 32'(spike_out), 32'hF);
    check("simul_fire_plus4", 32'(16'(fire_count - fc0)), 32'd4);
    step(6);

    // Disable mid-pulse: spike drops next cycle, counters hold.
    clear_chans();
    set_cfg(15, 1, 0, 7, 2);
    in_evt = 4'b0001;
    step(1);
    in_evt = 4'b0000;
    step(2);
    check("dis_in_fire", 32'(spike_out[0]), 32'd1);
    fc0 = fire_count; dc0 = drop_count;
    en = 1'b0; in_evt = 4'b1111;
    step(1);
    check("dis_spike_low", 32'(spike_out), 32'h0);
    check("dis_fire_hold", 32'(fire_count), 32'(fc0));
    check("dis_drop_hold", 32'(drop_count), 32'(dc0));
    in_evt = 4'b0000; en = 1'b1;
    step(2);

    // Reset mid-pulse.
    in_evt = 4'b1111;
    step(1);
    in_evt = 4'b0000;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_spike_out", 32'(spike_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fire_count", 32'(fire_count), 32'h0);
    check("rst_drop_count", 32'(drop_count), 32'h0);
    step(2);

    // Drop counter saturation: long busy stretches on all channels.
    set_cfg(15, 1, 0, 15, 15);
    in_evt = 4'b1111;
    reached = 0;
    for (int c = 0; c < 40000; c++) begin
      step(1);
      if (drop_count == 16'hFFFF) begin reached = 1; break; end
    end
    check("drop_sat_reached", 32'(reached), 32'd1);
    step(50);
    check("drop_sat_hold", 32'(drop_count), 32'hFFFF);
    in_evt = 4'b0000;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
